// File: rtl/pixel_plot_fifo.sv
// rtl/pixel_plot_fifo.sv - clipping pixel FIFO between drawing engines and vga_adapter
module pixel_plot_fifo #(
    parameter int DEPTH = 16,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_x,
    input  logic [6:0]               in_y,
    input  logic [2:0]               in_colour,
    input  logic                     in_plot,
    output logic                     in_ready,
    input  logic                     sink_ready,
    input  logic                     flush,
    output logic [7:0]               vga_x,
    output logic [6:0]               vga_y,
    output logic [2:0]               vga_colour,
    output logic                     vga_plot,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drained,
    output logic [15:0]              clip_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0] X_LIM = 8'(X_MAX);
    localparam logic [6:0] Y_LIM = 7'(Y_MAX);

    typedef enum logic [0:0] {RUN, FLUSH} state_t;

    state_t        state;
    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [17:0]   rd_word;
    logic          full;
    logic          clip;
    logic          push_ok;
    logic          do_write;
    logic          do_pop;

    // Level is a true occupancy counter, so full and empty never alias.
    assign full     = (level == LW'(DEPTH));
    assign in_ready = !rst && (state == RUN) && !full;
    assign clip     = (in_x > X_LIM) || (in_y > Y_LIM);
    // Flush takes priority over any push or pop in the same cycle.
    assign push_ok  = in_plot && in_ready && !flush;
    assign do_write = push_ok && !clip;
    assign do_pop   = (state == RUN) && !flush && (level != '0) && sink_ready;
    assign rd_word  = mem[rd_ptr];
    assign drained  = (level == '0) && !vga_plot;

    // Storage array; only on-screen pixels are written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= {in_x, in_y, in_colour};
        end
    end

    // Control FSM: pointers, occupancy, output register and clip counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            clip_count <= '0;
        end else if (state == FLUSH) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            vga_plot <= 1'b0;
            state    <= RUN;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            vga_plot <= 1'b0;
            state    <= FLUSH;
        end else begin
            if (do_write) begin
                wr_ptr <= AW'(wr_ptr + 1'b1);
            end
            if (push_ok && clip && (clip_count != 16'hFFFF)) begin
                clip_count <= clip_count + 16'd1;
            end
            if (do_pop) begin
                vga_x      <= rd_word[17:10];
                vga_y      <= rd_word[9:3];
                vga_colour <= rd_word[2:0];
                vga_plot   <= 1'b1;
                rd_ptr     <= AW'(rd_ptr + 1'b1);
            end else begin
                vga_plot <= 1'b0;
            end
            if (do_write && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_write && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_plot_fifo.sv
// tb/tb_pixel_plot_fifo.sv - directed self-checking bench for pixel_plot_fifo
module tb_pixel_plot_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_plot;
    logic        in_ready;
    logic        sink_ready;
    logic        flush;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [4:0]  level;
    logic        drained;
    logic [15:0] clip_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        toggle_sink = 1'b0;
    logic [17:0] got[$];
    logic [17:0] exp_q[$];

    pixel_plot_fifo #(.DEPTH(16), .X_MAX(159), .Y_MAX(119)) dut (
        .clk(clk), .rst(rst), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
        .in_plot(in_plot), .in_ready(in_ready), .sink_ready(sink_ready), .flush(flush),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .level(level), .drained(drained), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    // Record every plot strobe away from the active edge.
    always @(negedge clk) begin
        if (vga_plot) got.push_back({vga_x, vga_y, vga_colour});
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_sink) sink_ready = ~sink_ready;
    endtask

    task automatic push(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        int guard = 0;
        in_x = x; in_y = y; in_colour = c; in_plot = 1'b1;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check_eq("push_timeout", 32'(guard), 32'd0);
        tick();
        in_plot = 1'b0;
    endtask

    task automatic drain_wait();
        int guard = 0;
        while (!drained && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check_eq("drain_timeout", 32'(guard), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        int n0;
        rst = 1'b1; in_x = '0; in_y = '0; in_colour = '0; in_plot = 1'b0;
        sink_ready = 1'b1; flush = 1'b0;
        #1;
        check_eq("ready_in_reset", in_ready, 1'b0);
        tick(); tick();
        check_eq("rst_level", level, 0);
        check_eq("rst_plot", vga_plot, 0);
        check_eq("rst_clip", clip_count, 0);
        check_eq("rst_vga_x", vga_x, 0);
        rst = 1'b0;
        #1;
        check_eq("rst_drained", drained, 1);
        check_eq("rst_ready_after", in_ready, 1);

        // 1: single pixel, one-cycle latency after the push edge
        got.delete();
        push(8'd5, 7'd7, 3'b010);
        check_eq("t1_level", level, 1);
        check_eq("t1_plot_early", vga_plot, 0);
        tick();
        check_eq("t1_plot", vga_plot, 1);
        check_eq("t1_pix", {vga_x, vga_y, vga_colour}, {8'd5, 7'd7, 3'd2});
        tick();
        check_eq("t1_plot_off", vga_plot, 0);
        check_eq("t1_drained", drained, 1);
        check_eq("t1_count", got.size(), 1);

        // 2: fill to full with the sink stalled, then drain in order
        sink_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i), 7'd0, 3'd1);
        check_eq("t2_level_full", level, 16);
        check_eq("t2_ready_full", in_ready, 0);
        in_x = 8'd99; in_plot = 1'b1;
        tick();
        in_plot = 1'b0;
        check_eq("t2_level_17th", level, 16);
        got.delete();
        sink_ready = 1'b1;
        drain_wait();
        check_eq("t2_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            check_eq($sformatf("t2_x%0d", i), got[i][17:10], 8'(i));

        // 3: clipping on each axis, then the corner pixel passes unchanged
        got.delete();
        push(8'd160, 7'd0, 3'd3);
        push(8'd0, 7'd120, 3'd3);
        check_eq("t3_clip", clip_count, 2);
        check_eq("t3_level", level, 0);
        repeat (3) tick();
        check_eq("t3_no_plot", got.size(), 0);
        push(8'd159, 7'd119, 3'd5);
        drain_wait();
        check_eq("t3_corner_count", got.size(), 1);
        if (got.size() > 0) check_eq("t3_corner", got[0], {8'd159, 7'd119, 3'd5});

        // 4: 40 pixels with a toggling sink exercises pointer wrap
        got.delete();
        exp_q.delete();
        toggle_sink = 1'b1;
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back({8'(i * 3), 7'(i), 3'(i)});
            push(8'(i * 3), 7'(i), 3'(i));
        end
        toggle_sink = 1'b0;
        sink_ready = 1'b1;
        drain_wait();
        check_eq("t4_count", got.size(), 40);
        for (int i = 0; i < 40 && i < got.size(); i++)
            check_eq($sformatf("t4_pix%0d", i), got[i], exp_q[i]);

        // 5: flush with a (clipped) push in the same cycle
        sink_ready = 1'b0;
        for (int i = 0; i < 9; i++) push(8'(i), 7'd1, 3'd4);
        check_eq("t5_level9", level, 9);
        n0 = got.size();
        in_x = 8'd200; in_y = 7'd0; in_plot = 1'b1; flush = 1'b1;
        tick();
        in_plot = 1'b0; flush = 1'b0;
        check_eq("t5_level0", level, 0);
        check_eq("t5_plot", vga_plot, 0);
        check_eq("t5_clip_kept", clip_count, 2);
        check_eq("t5_ready_flush", in_ready, 0);
        tick();
        check_eq("t5_ready_after", in_ready, 1);
        sink_ready = 1'b1;
        repeat (5) tick();
        check_eq("t5_no_emit", got.size(), n0);

        // 6: reset with stored pixels drops them
        sink_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(i), 7'd2, 3'd6);
        check_eq("t6_level5", level, 5);
        n0 = got.size();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_level0", level, 0);
        check_eq("t6_plot", vga_plot, 0);
        check_eq("t6_clip0", clip_count, 0);
        sink_ready = 1'b1;
        repeat (8) tick();
        check_eq("t6_no_emit", got.size(), n0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
